// File: rtl/playfield_writer_pkg.sv
// Shared definitions for the playfield writer: register map, STATUS layout and
// the fill sequencer state encoding.
package playfield_writer_pkg;

    localparam logic [1:0] REG_CURSOR = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_FILL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int ST_OVERFLOW  = 7;
    localparam int ST_BUSY      = 6;
    localparam int ST_FULL      = 5;
    localparam int ST_EMPTY     = 4;
    localparam int ST_LEVEL_LSB = 0;

    localparam int ADDR_W  = 10;
    localparam int TILE_W  = 8;
    localparam int ENTRY_W = ADDR_W + TILE_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_t;

    function automatic logic [11:0] pack_status(input logic ovf, input logic busy,
                                                input logic full, input logic empty,
                                                input logic [3:0] level);
        return {4'b0000, ovf, busy, full, empty, level};
    endfunction

endpackage

// File: rtl/playfield_writer_if.sv
// CPU register bus seen by the playfield writer.
interface playfield_writer_if;

    logic        io_sel;
    logic        io_write;
    logic [1:0]  io_reg;
    logic [11:0] io_wr_data;
    logic [11:0] io_rd_data;

    modport master (output io_sel, io_write, io_reg, io_wr_data, input io_rd_data);
    modport slave  (input io_sel, io_write, io_reg, io_wr_data, output io_rd_data);

endinterface

// File: rtl/playfield_writer_fifo.sv
// Pending playfield writes; first-word-fall-through read, caller guarantees
// no push when full without a pop and no pop when empty.
module pf_write_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign pop_data = mem[rptr];
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);

endmodule

// File: rtl/playfield_writer.sv
// CPU-facing playfield writer: register file, fill sequencer and a write FIFO
// that drains into playfield RAM only during blanking.
module playfield_writer
    import playfield_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                i_Clk,
    input  logic                reset,
    playfield_writer_if.slave   bus,
    input  logic                blank,
    output logic                pf_write,
    output logic [ADDR_W-1:0]   pf_write_addr,
    output logic [TILE_W-1:0]   pf_wr_data
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    fill_state_t        state;
    fill_state_t        state_nxt;
    logic [ADDR_W-1:0]  cursor;
    logic [ADDR_W-1:0]  fill_count;
    logic [TILE_W-1:0]  last_data;
    logic               overflow;

    logic               wr, wr_cursor, wr_data, wr_fill, wr_status;
    logic               cpu_push, fill_push, push, pop, set_ovf;
    logic               full, empty, busy;
    logic [LW-1:0]      level;
    logic [ENTRY_W-1:0] push_entry, pop_entry;
    logic               unused_bits;

    assign wr        = bus.io_sel & bus.io_write;
    assign wr_cursor = wr && (bus.io_reg == REG_CURSOR);
    assign wr_data   = wr && (bus.io_reg == REG_DATA);
    assign wr_fill   = wr && (bus.io_reg == REG_FILL);
    assign wr_status = wr && (bus.io_reg == REG_STATUS);
    assign pop       = blank & ~empty;
    assign busy      = (state == S_FILL) | ~empty;
    assign unused_bits = ^bus.io_wr_data[11:10];

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // A full FIFO still takes a CPU push when the same cycle pops; the fill
    // sequencer instead just waits for room.
    always_comb begin
        state_nxt = state;
        cpu_push  = 1'b0;
        fill_push = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_push = wr_data & (~full | pop);
                set_ovf  = wr_data & ~cpu_push;
                if (wr_fill && (bus.io_wr_data[ADDR_W-1:0] != '0)) state_nxt = S_FILL;
            end
            S_FILL: begin
                fill_push = ~full;
                set_ovf   = wr_data | wr_cursor | wr_fill;
                if (fill_push && (fill_count == 10'd1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        push       = cpu_push | fill_push;
        push_entry = {cursor, cpu_push ? bus.io_wr_data[TILE_W-1:0] : last_data};
    end

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) begin
            cursor     <= '0;
            fill_count <= '0;
            last_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                cursor <= cursor + 10'd1;
            else if (state == S_IDLE && wr_cursor)
                cursor <= bus.io_wr_data[ADDR_W-1:0];
            if (state == S_IDLE && wr_data)
                last_data <= bus.io_wr_data[TILE_W-1:0];
            if (state == S_IDLE && wr_fill)
                fill_count <= bus.io_wr_data[ADDR_W-1:0];
            else if (fill_push)
                fill_count <= fill_count - 10'd1;
            if (set_ovf)
                overflow <= 1'b1;
            else if (wr_status && bus.io_wr_data[0])
                overflow <= 1'b0;
        end
    end

    pf_write_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk       (i_Clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) begin
            pf_write      <= 1'b0;
            pf_write_addr <= '0;
            pf_wr_data    <= '0;
        end else begin
            pf_write <= pop;
            if (pop) {pf_write_addr, pf_wr_data} <= pop_entry;
        end
    end

    always_comb begin
        bus.io_rd_data = '0;
        if (bus.io_sel) begin
            case (bus.io_reg)
                REG_CURSOR: bus.io_rd_data = {2'b00, cursor};
                REG_DATA:   bus.io_rd_data = {4'b0000, last_data};
                REG_FILL:   bus.io_rd_data = {2'b00, fill_count};
                default:    bus.io_rd_data = pack_status(overflow, busy, full, empty, 4'(level));
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_writer.sv
// Directed bench for playfield_writer: register access, FIFO ordering and
// overflow, cursor wrap, fill sequencing and reset in the middle of a fill.
module tb_playfield_writer;
    import playfield_writer_pkg::*;

    logic       i_Clk = 1'b0;
    logic       reset = 1'b1;
    logic       blank_req = 1'b0;
    logic       toggle_en = 1'b0;
    logic       tog = 1'b0;
    logic       blank;
    logic       pf_write;
    logic [9:0] pf_write_addr;
    logic [7:0] pf_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t q[$];

    assign blank = toggle_en ? tog : blank_req;

    playfield_writer_if bus();

    playfield_writer #(.FIFO_DEPTH(8)) dut (
        .i_Clk         (i_Clk),
        .reset         (reset),
        .bus           (bus),
        .blank         (blank),
        .pf_write      (pf_write),
        .pf_write_addr (pf_write_addr),
        .pf_wr_data    (pf_wr_data)
    );

    always #20 i_Clk = ~i_Clk;

    // Records every RAM write pulse and, when enabled, drives a 3-on/3-off blank.
    initial begin
        wr_t e;
        forever begin
            @(negedge i_Clk);
            cyc++;
            if (pf_write) begin
                e.addr = pf_write_addr;
                e.data = pf_wr_data;
                e.cyc  = cyc;
                q.push_back(e);
            end
            if (toggle_en && (cyc % 3 == 0)) tog = ~tog;
        end
    end

    initial begin
        #2400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] r, input logic [11:0] d);
        @(negedge i_Clk);
        bus.io_sel     = 1'b1;
        bus.io_write   = 1'b1;
        bus.io_reg     = r;
        bus.io_wr_data = d;
    endtask

    task automatic cpu_idle();
        @(negedge i_Clk);
        bus.io_sel   = 1'b0;
        bus.io_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] r, output logic [11:0] v);
        @(negedge i_Clk);
        bus.io_sel   = 1'b1;
        bus.io_write = 1'b0;
        bus.io_reg   = r;
        #1 v = bus.io_rd_data;
        bus.io_sel = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [9:0] a, input logic [7:0] d);
        wr_t e;
        if (q.size() == 0) begin
            check_eq({tag, "_present"}, 0, 1);
        end else begin
            e = q.pop_front();
            check_eq({tag, "_addr"}, {22'd0, e.addr}, {22'd0, a});
            check_eq({tag, "_data"}, {24'd0, e.data}, {24'd0, d});
        end
    endtask

    initial begin
        logic [11:0] v;
        wr_t         e0, e1;
        int          errs;
        logic        done;

        bus.io_sel = 1'b0; bus.io_write = 1'b0; bus.io_reg = 2'd0; bus.io_wr_data = '0;

        // Reset state
        repeat (3) @(negedge i_Clk);
        check_eq("rst_pf_write", {31'd0, pf_write}, 0);
        check_eq("rst_pf_addr", {22'd0, pf_write_addr}, 0);
        check_eq("rst_pf_data", {24'd0, pf_wr_data}, 0);
        reset = 1'b0;
        repeat (2) @(negedge i_Clk);
        check_eq("rst_no_pulse", q.size(), 0);
        cpu_rd(REG_STATUS, v); check_eq("rst_status", v, 12'h010);
        cpu_rd(REG_CURSOR, v); check_eq("rst_cursor", v, 12'h000);

        // Two DATA writes during blank retire on consecutive cycles
        blank_req = 1'b1;
        cpu_wr(REG_CURSOR, 12'h3A0);
        cpu_wr(REG_DATA, 12'd26);
        cpu_wr(REG_DATA, 12'd26);
        cpu_idle();
        repeat (4) @(negedge i_Clk);
        check_eq("pair_count", q.size(), 2);
        if (q.size() >= 2) begin
            e0 = q[0]; e1 = q[1];
            check_eq("pair_consecutive", e1.cyc - e0.cyc, 1);
        end
        expect_wr("pair0", 10'h3A0, 8'd26);
        expect_wr("pair1", 10'h3A1, 8'd26);
        cpu_rd(REG_CURSOR, v); check_eq("pair_cursor", v, 12'h3A2);

        // Nine writes with no blank: eighth fills, ninth overflows without moving CURSOR
        blank_req = 1'b0;
        cpu_wr(REG_CURSOR, 12'h100);
        for (int i = 0; i < 9; i++) cpu_wr(REG_DATA, 12'(8'h10 + i));
        cpu_idle();
        cpu_rd(REG_STATUS, v); check_eq("ovf_status", v, 12'h0E8);
        cpu_rd(REG_CURSOR, v); check_eq("ovf_cursor", v, 12'h108);
        blank_req = 1'b1;
        repeat (12) @(negedge i_Clk);
        check_eq("ovf_count", q.size(), 8);
        for (int i = 0; i < 8; i++) expect_wr($sformatf("ovf%0d", i), 10'(10'h100 + i), 8'(8'h10 + i));
        cpu_rd(REG_STATUS, v); check_eq("ovf_sticky", v, 12'h090);
        cpu_wr(REG_STATUS, 12'h001);
        cpu_idle();
        cpu_rd(REG_STATUS, v); check_eq("ovf_cleared", v, 12'h010);

        // Cursor wrap
        cpu_wr(REG_CURSOR, 12'd1022);
        cpu_wr(REG_DATA, 12'd1);
        cpu_wr(REG_DATA, 12'd2);
        cpu_wr(REG_DATA, 12'd3);
        cpu_idle();
        repeat (4) @(negedge i_Clk);
        expect_wr("wrap0", 10'd1022, 8'd1);
        expect_wr("wrap1", 10'd1023, 8'd2);
        expect_wr("wrap2", 10'd0, 8'd3);
        cpu_rd(REG_CURSOR, v); check_eq("wrap_cursor", v, 12'd1);

        // Full FIFO, push coinciding with a pop is accepted
        blank_req = 1'b0;
        cpu_wr(REG_CURSOR, 12'h200);
        for (int i = 0; i < 8; i++) cpu_wr(REG_DATA, 12'(8'h40 + i));
        cpu_idle();
        cpu_rd(REG_STATUS, v); check_eq("full_status", v, 12'h068);
        cpu_wr(REG_DATA, 12'h077);
        blank_req = 1'b1;
        cpu_idle();
        blank_req = 1'b0;
        cpu_rd(REG_STATUS, v); check_eq("simul_status", v, 12'h068);
        blank_req = 1'b1;
        repeat (14) @(negedge i_Clk);
        check_eq("simul_count", q.size(), 9);
        for (int i = 0; i < 8; i++) expect_wr($sformatf("simul%0d", i), 10'(10'h200 + i), 8'(8'h40 + i));
        expect_wr("simul8", 10'h208, 8'h77);
        cpu_rd(REG_STATUS, v); check_eq("simul_after", v, 12'h010);

        // A count of 0x400 truncates to zero in the 10-bit field: no fill starts
        blank_req = 1'b0;
        cpu_wr(REG_FILL, 12'h400);
        cpu_idle();
        cpu_rd(REG_FILL, v);   check_eq("fill0_count", v, 12'h000);
        cpu_rd(REG_STATUS, v); check_eq("fill0_status", v, 12'h010);

        // 1024 cells of tile 5: one DATA push then a 1023-cell fill, blank toggling
        cpu_wr(REG_CURSOR, 12'h000);
        cpu_wr(REG_DATA, 12'd5);
        cpu_wr(REG_FILL, 12'd1023);
        cpu_idle();
        toggle_en = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            cpu_rd(REG_STATUS, v);
            if (!v[ST_BUSY]) done = 1'b1;
        end
        toggle_en = 1'b0;
        blank_req = 1'b0;
        repeat (3) @(negedge i_Clk);
        check_eq("fill_done", {31'd0, done}, 1);
        check_eq("fill_count", q.size(), 1024);
        errs = 0;
        for (int i = 0; i < 1024 && q.size() > 0; i++) begin
            e0 = q.pop_front();
            if (e0.addr != 10'(i) || e0.data != 8'd5) errs++;
        end
        check_eq("fill_order", errs, 0);
        cpu_rd(REG_STATUS, v); check_eq("fill_status", v, 12'h010);
        cpu_rd(REG_CURSOR, v); check_eq("fill_cursor", v, 12'h000);

        // Stalled fill does not flag overflow; a DATA write during fill does
        cpu_wr(REG_FILL, 12'd20);
        cpu_idle();
        repeat (10) @(negedge i_Clk);
        cpu_rd(REG_STATUS, v); check_eq("stall_status", v, 12'h068);
        cpu_rd(REG_FILL, v);   check_eq("stall_remaining", v, 12'd12);
        cpu_wr(REG_DATA, 12'h099);
        cpu_idle();
        cpu_rd(REG_STATUS, v); check_eq("midfill_ovf", v, 12'h0E8);
        cpu_rd(REG_DATA, v);   check_eq("midfill_data", v, 12'h005);
        blank_req = 1'b1;
        repeat (30) @(negedge i_Clk);
        check_eq("midfill_count", q.size(), 20);
        cpu_rd(REG_STATUS, v); check_eq("midfill_after", v, 12'h090);
        cpu_rd(REG_CURSOR, v); check_eq("midfill_cursor", v, 12'd20);
        cpu_wr(REG_STATUS, 12'h001);
        cpu_idle();
        q.delete();

        // Reset in the middle of a fill with five entries pending and a write in flight
        blank_req = 1'b0;
        cpu_wr(REG_FILL, 12'd20);
        cpu_idle();
        repeat (5) @(negedge i_Clk);
        blank_req = 1'b1;
        @(negedge i_Clk);
        check_eq("prerst_pf_write", {31'd0, pf_write}, 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_pf_write", {31'd0, pf_write}, 0);
        check_eq("midrst_pf_addr", {22'd0, pf_write_addr}, 0);
        check_eq("midrst_pf_data", {24'd0, pf_wr_data}, 0);
        q.delete();
        @(negedge i_Clk);
        reset = 1'b0;
        repeat (3) @(negedge i_Clk);
        check_eq("postrst_no_write", q.size(), 0);
        cpu_rd(REG_STATUS, v); check_eq("postrst_status", v, 12'h010);
        cpu_rd(REG_CURSOR, v); check_eq("postrst_cursor", v, 12'h000);
        cpu_rd(REG_FILL, v);   check_eq("postrst_fill", v, 12'h000);
        cpu_rd(REG_DATA, v);   check_eq("postrst_data", v, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
